cass_sd_arbiter: RTL and testbench

Shares the single cassette SD image block port between the cassette playback reader (requester R) and the cassette record writer (requester W).
- Latches one requester's LBA and operation and drives sd_lba/sd_rd/sd_wr.
- Steers sd_ack back to the owner and muxes the owner's buffer read data onto sd_buff_din.
- Arbitrates round-robin on simultaneous requests.
- Aborts transfers the host never acknowledges.
- Sits between the two cassette blocks and the top-level SD/HPS block interface.

---
 rtl/cass_sd_arbiter.sv | 100 ++++++++++
 tb/tb_cass_sd_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cass_sd_arbiter.sv
// rtl/cass_sd_arbiter.sv - round-robin arbiter sharing the cassette SD block port between reader R and writer W
module cass_sd_arbiter #(
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd8_000_000
) (
  input  logic        clock,
  input  logic        RESET_N,
  input  logic [31:0] r_lba,
  input  logic        r_rd,
  input  logic        r_wr,
  output logic        r_ack,
  input  logic [7:0]  r_buff_din,
  input  logic [31:0] w_lba,
  input  logic        w_rd,
  input  logic        w_wr,
  output logic        w_ack,
  input  logic [7:0]  w_buff_din,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  output logic [7:0]  sd_buff_din,
  output logic        owner,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [TIMEOUT_W-1:0] TIMER_ONE  = 1;
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_CYCLES - TIMER_ONE;

  logic [1:0]           state;
  logic                 op_wr;
  logic                 rr_ptr;
  logic [TIMEOUT_W-1:0] timer;

  logic r_pend;
  logic w_pend;
  logic grant_w;

  assign r_pend  = r_rd | r_wr;
  assign w_pend  = w_rd | w_wr;
  // W wins when it is the only one pending, or when both are and the pointer favours W
  assign grant_w = w_pend & (~r_pend | rr_ptr);

  assign busy        = (state != S_IDLE);
  assign sd_rd       = (state == S_REQ) & ~op_wr;
  assign sd_wr       = (state == S_REQ) & op_wr;
  assign r_ack       = sd_ack & ~owner & busy;
  assign w_ack       = sd_ack & owner & busy;
  assign sd_buff_din = owner ? w_buff_din : r_buff_din;

  always_ff @(posedge clock or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      sd_lba      <= 32'd0;
      op_wr       <= 1'b0;
      owner       <= 1'b0;
      rr_ptr      <= 1'b0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (r_pend | w_pend) begin
            state  <= S_REQ;
            owner  <= grant_w;
            sd_lba <= grant_w ? w_lba : r_lba;
            op_wr  <= grant_w ? w_wr : r_wr;
          end
        end
        S_REQ: begin
          if (sd_ack) begin
            timer <= '0;
            state <= S_ACK;
          end else if (timer == TIMER_LAST) begin
            timer       <= '0;
            timeout_err <= 1'b1;
            state       <= S_DONE;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        S_ACK: begin
          if (!sd_ack) state <= S_DONE;
        end
        default: begin
          rr_ptr <= ~owner;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cass_sd_arbiter.sv
// tb/tb_cass_sd_arbiter.sv - scoreboard bench for cass_sd_arbiter
module tb_cass_sd_arbiter;

  logic        clock = 1'b0;
  logic        RESET_N;
  logic [31:0] r_lba, w_lba, sd_lba;
  logic        r_rd, r_wr, w_rd, w_wr;
  logic        r_ack, w_ack;
  logic [7:0]  r_buff_din, w_buff_din, sd_buff_din;
  logic        sd_rd, sd_wr, sd_ack;
  logic        owner, busy, timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // entry layout: {owner, wr, rd, lba, buff data}
  logic [42:0] sb[$];
  logic [42:0] cur;
  logic        prev_strobe = 1'b0;

  cass_sd_arbiter #(.TIMEOUT_W(24), .TIMEOUT_CYCLES(24'd16)) dut (
    .clock(clock), .RESET_N(RESET_N),
    .r_lba(r_lba), .r_rd(r_rd), .r_wr(r_wr), .r_ack(r_ack), .r_buff_din(r_buff_din),
    .w_lba(w_lba), .w_rd(w_rd), .w_wr(w_wr), .w_ack(w_ack), .w_buff_din(w_buff_din),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_din(sd_buff_din), .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic own, input logic wr, input logic [31:0] lba, input logic [7:0] data);
    sb.push_back({own, wr, ~wr, lba, data});
  endtask

  // compare each new strobe against the scoreboard, then hold lba/data/op for its duration
  always @(negedge clock) begin
    #1;
    if (!RESET_N) begin
      prev_strobe = 1'b0;
    end else begin
      if ((sd_rd | sd_wr) && !prev_strobe) begin
        if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
        else begin
          cur = sb.pop_front();
          check("txn", {owner, sd_wr, sd_rd, sd_lba, sd_buff_din}, cur);
        end
      end else if (sd_rd | sd_wr) begin
        check("txn_hold", {owner, sd_wr, sd_rd, sd_lba, sd_buff_din}, cur);
      end
      prev_strobe = sd_rd | sd_wr;
    end
  end

  task automatic wait_strobe();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (sd_rd | sd_wr) seen = 1;
    end
    if (!seen) check("strobe_timeout", 64'd0, 64'd1);
  endtask

  // host acks after `dly` cycles; requester drops its request once acked
  task automatic serve(input int dly, input logic exp_own);
    wait_strobe();
    repeat (dly) @(negedge clock);
    sd_ack = 1'b1;
    #1;
    check("r_ack", r_ack, !exp_own);
    check("w_ack", w_ack, exp_own);
    @(negedge clock);
    check("strobe_drop", sd_rd | sd_wr, 0);
    check("ack_hold", exp_own ? w_ack : r_ack, 1);
    if (exp_own) begin w_rd = 0; w_wr = 0; end
    else begin r_rd = 0; r_wr = 0; end
    sd_ack = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    @(negedge clock);
    RESET_N = 1'b1;
  endtask

  initial begin
    int cnt, pulses;
    RESET_N = 0; sd_ack = 0;
    r_lba = 0; r_rd = 0; r_wr = 0; r_buff_din = 8'hAA;
    w_lba = 0; w_rd = 0; w_wr = 0; w_buff_din = 8'h55;
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_strobes", {sd_rd, sd_wr}, 0);
    check("rst_owner", owner, 0);
    check("rst_lba", sd_lba, 0);
    check("rst_terr", timeout_err, 0);
    RESET_N = 1;

    // R only
    @(negedge clock);
    r_rd = 1; r_lba = 32'h10; push(0, 0, 32'h10, 8'hAA);
    @(negedge clock);
    check("t1_sd_rd", sd_rd, 1);
    check("t1_lba", sd_lba, 32'h10);
    serve(4, 0);
    @(negedge clock);
    check("t1_busy_done", busy, 1);
    @(negedge clock);
    check("t1_busy_idle", busy, 0);

    // simultaneous after reset: R, then W (R re-requests but rr_ptr favours W), then R
    do_reset();
    r_rd = 1; r_lba = 32'h20; w_wr = 1; w_lba = 32'h30;
    push(0, 0, 32'h20, 8'hAA);
    push(1, 1, 32'h30, 8'h55);
    serve(3, 0);
    r_rd = 1; r_lba = 32'h21; push(0, 0, 32'h21, 8'hAA);
    serve(3, 1);
    serve(2, 0);
    repeat (3) @(negedge clock);
    check("t2_idle", busy, 0);

    // timeout on W with lba change mid-transfer, R pending gets granted next
    do_reset();
    w_wr = 1; w_lba = 32'd3; push(1, 1, 32'd3, 8'h55);
    push(0, 0, 32'h40, 8'hAA);
    cnt = 0; pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (i == 3) w_lba = 32'd9;
      if (i == 5) begin r_rd = 1; r_lba = 32'h40; end
      if (i == 20) w_wr = 0;
      if (sd_wr) cnt++;
      if (timeout_err) pulses++;
    end
    check("t4_wr_cycles", cnt, 16);
    check("t4_terr_pulses", pulses, 1);
    check("t4_owner_r", owner, 0);
    serve(2, 0);
    repeat (3) @(negedge clock);

    // W drops request before ack: transfer still completes
    w_wr = 1; w_lba = 32'd5; push(1, 1, 32'd5, 8'h55);
    @(negedge clock);
    w_wr = 0;
    serve(2, 1);
    repeat (2) @(negedge clock);
    check("t5_idle", busy, 0);

    // async reset during REQ
    w_wr = 1; w_lba = 32'd7; push(1, 1, 32'd7, 8'h55);
    @(negedge clock);
    check("t6_sd_wr", sd_wr, 1);
    #2 RESET_N = 0;
    #1;
    check("t6_rst_sd_wr", sd_wr, 0);
    check("t6_rst_busy", busy, 0);
    sd_ack = 1; w_wr = 0;
    @(negedge clock);
    RESET_N = 1;
    @(negedge clock);
    check("t6_stale_acks", {r_ack, w_ack}, 0);
    check("t6_idle", busy, 0);
    sd_ack = 0;

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
